// File: rtl/mio_bus_arbiter_pkg.sv
// mio_arb_pkg: shared types and constants for the MIO bus arbiter.
//   state_t : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   GNT_*   : grant encodings (none / CPU / DMA)
//   CNT_W   : width of the memory-latency wait counter
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  // Wide enough for MEM_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// mio_bus_arbiter_if: bundles the two requester ports, the memory bus and
// the grant indication of the MIO bus arbiter.
//   modport master : arbiter side (drives acks, rdata, mem_*, grant)
//   modport slave  : environment side (requesters + memory)
// Parameters: ADDR_W, DATA_W.
interface mio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  // DMA/VGA requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  // Memory bus
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Current owner
  logic [1:0]        grant;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, grant
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, grant
  );

endinterface

// File: rtl/mio_bus_arbiter_rr_pick.sv
// mio_rr_pick: combinational 2-way winner selection.
//   cpu_req, dma_req : pending requests
//   last_grant       : owner of the previous completed access
//   pick             : GNT_NONE / GNT_CPU / GNT_DMA
// Build option: ARB_CPU_PRIO_EN -> CPU always wins ties (last_grant ignored);
// otherwise round-robin on ties.
module mio_rr_pick
  import mio_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic [1:0] last_grant,
  output logic [1:0] pick
);

`ifdef ARB_CPU_PRIO_EN
  // Fixed priority never looks at history.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    pick = GNT_NONE;
    if (cpu_req)      pick = GNT_CPU;
    else if (dma_req) pick = GNT_DMA;
  end
`else
  always_comb begin
    pick = GNT_NONE;
    if (cpu_req && dma_req)
      // Tie goes to whoever did not own the bus last.
      pick = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
    else if (cpu_req)
      pick = GNT_CPU;
    else if (dma_req)
      pick = GNT_DMA;
  end
`endif

endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one fixed-latency memory bus between the CPU
// controller (port 0) and a DMA/VGA fetch engine (port 1), one access at a
// time: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (MEM_LAT) -> RESP (ack).
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : mio_bus_arbiter_if.master (requesters, memory bus, grant)
// Parameters: ADDR_W, DATA_W (must match the interface), MEM_LAT (1..15).
// Build option: ARB_CPU_PRIO_EN selects fixed CPU priority instead of
// round-robin (see mio_rr_pick).
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  mio_bus_arbiter_if.master   bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_grant;
  logic [1:0]       pick;

  mio_rr_pick u_pick (
    .cpu_req    (bus.cpu_req),
    .dma_req    (bus.dma_req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= GNT_DMA;  // CPU wins the first tie
      bus.grant     <= GNT_NONE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      bus.mem_en  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            bus.grant  <= pick;
            bus.mem_en <= 1'b1;  // high for the whole ISSUE cycle
            if (pick == GNT_CPU) begin
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
            end else begin
              bus.mem_we    <= bus.dma_we;
              bus.mem_addr  <= bus.dma_addr;
              bus.mem_wdata <= bus.dma_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MEM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // cnt==1 marks the cycle in which mem_rdata is valid.
          if (cnt == CNT_W'(1)) begin
            if (!bus.mem_we) begin
              if (bus.grant == GNT_CPU) bus.cpu_rdata <= bus.mem_rdata;
              else                      bus.dma_rdata <= bus.mem_rdata;
            end
            bus.cpu_ack <= (bus.grant == GNT_CPU);
            bus.dma_ack <= (bus.grant == GNT_DMA);
            state       <= RESP;
          end
        end
        RESP: begin
          last_grant <= bus.grant;
          bus.grant  <= GNT_NONE;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed self-checking bench for mio_bus_arbiter.
// Two DUTs: u_dut0 at MEM_LAT=2 (main tests) and u_dut1 at MEM_LAT=1.
// Expected round-robin vs fixed-priority order follows ARB_CPU_PRIO_EN.
module tb_mio_bus_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x10 holds DEADBEEF, everything else A5A5_<addr[15:0]>.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
  endfunction

  // Fixed-latency memories; data is poisoned outside its valid cycle.
  logic [31:0] p0_0, p0_1, p1_0;
  logic        v0_0, v0_1, v1_0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_0 <= 1'b0; v0_1 <= 1'b0; v1_0 <= 1'b0;
      p0_0 <= '0;   p0_1 <= '0;   p1_0 <= '0;
    end else begin
      p0_0 <= memf(b0.mem_addr); v0_0 <= b0.mem_en;
      p0_1 <= p0_0;              v0_1 <= v0_0;
      p1_0 <= memf(b1.mem_addr); v1_0 <= b1.mem_en;
    end
  end
  assign b0.mem_rdata = v0_1 ? p0_1 : 32'hBAD0BAD0;
  assign b1.mem_rdata = v1_0 ? p1_0 : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [1:0] exp_g;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
    b0.dma_req = 0; b0.dma_we = 0; b0.dma_addr = '0; b0.dma_wdata = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = '0; b1.dma_wdata = '0;
    tick();
    tick();
    // Reset state
    chk("rst_grant", b0.grant, 2'b00);
    chk("rst_mem_en", b0.mem_en, 1'b0);
    chk("rst_mem_we", b0.mem_we, 1'b0);
    chk("rst_mem_addr", b0.mem_addr, 32'h0);
    chk("rst_mem_wdata", b0.mem_wdata, 32'h0);
    chk("rst_cpu_ack", b0.cpu_ack, 1'b0);
    chk("rst_dma_ack", b0.dma_ack, 1'b0);
    chk("rst_cpu_rdata", b0.cpu_rdata, 32'h0);
    chk("rst_dma_rdata", b0.dma_rdata, 32'h0);
    reset = 1'b0;
    tick();
    chk("idle_grant", b0.grant, 2'b00);

    // T1: CPU read of 0x10
    b0.cpu_addr = 32'h10; b0.cpu_we = 0; b0.cpu_req = 1;   // cycle 0
    tick();                                                // cycle 1
    chk("t1_c1_mem_en", b0.mem_en, 1'b1);
    chk("t1_c1_grant", b0.grant, 2'b01);
    chk("t1_c1_mem_addr", b0.mem_addr, 32'h10);
    chk("t1_c1_mem_we", b0.mem_we, 1'b0);
    tick();                                                // cycle 2
    chk("t1_c2_mem_en", b0.mem_en, 1'b0);
    chk("t1_c2_ack", b0.cpu_ack, 1'b0);
    tick();                                                // cycle 3
    chk("t1_c3_ack", b0.cpu_ack, 1'b0);
    tick();                                                // cycle 4
    chk("t1_c4_ack", b0.cpu_ack, 1'b1);
    chk("t1_c4_dma_ack", b0.dma_ack, 1'b0);
    chk("t1_c4_rdata", b0.cpu_rdata, 32'hDEADBEEF);
    b0.cpu_req = 0;
    tick();                                                // cycle 5
    chk("t1_c5_ack", b0.cpu_ack, 1'b0);
    chk("t1_c5_grant", b0.grant, 2'b00);

    // T2: both request right after reset -> CPU then DMA
    do_reset();
    b0.cpu_addr = 32'h10; b0.cpu_req = 1;
    b0.dma_addr = 32'h20; b0.dma_we = 0; b0.dma_req = 1;  // cycle 0
    tick();
    chk("t2_c1_grant", b0.grant, 2'b01);
    tick(); tick(); tick();                               // cycle 4
    chk("t2_c4_cpu_ack", b0.cpu_ack, 1'b1);
    chk("t2_c4_dma_ack", b0.dma_ack, 1'b0);
    b0.cpu_req = 0;
    tick();                                               // cycle 5
    chk("t2_c5_grant", b0.grant, 2'b00);
    tick();                                               // cycle 6
    chk("t2_c6_grant", b0.grant, 2'b10);
    chk("t2_c6_mem_addr", b0.mem_addr, 32'h20);
    tick(); tick();                                       // cycle 8
    chk("t2_c8_dma_ack", b0.dma_ack, 1'b0);
    tick();                                               // cycle 9
    chk("t2_c9_dma_ack", b0.dma_ack, 1'b1);
    chk("t2_c9_cpu_ack", b0.cpu_ack, 1'b0);
    chk("t2_c9_dma_rdata", b0.dma_rdata, 32'hA5A50020);
    b0.dma_req = 0;
    tick();

    // T3: both held for 6 accesses
    b0.cpu_req = 1; b0.dma_req = 1;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_CPU_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tick();                                             // ISSUE
      chk($sformatf("t3_grant%0d", k), b0.grant, exp_g);
      tick(); tick(); tick();                             // RESP
      chk($sformatf("t3_cpu_ack%0d", k), b0.cpu_ack, exp_g == 2'b01);
      chk($sformatf("t3_dma_ack%0d", k), b0.dma_ack, exp_g == 2'b10);
      if (k == 5) begin
        b0.cpu_req = 0; b0.dma_req = 0;
      end
      tick();                                             // IDLE
    end

    // T4: DMA write; later address/data changes must be ignored
    b0.dma_we = 1; b0.dma_addr = 32'h40; b0.dma_wdata = 32'h12345678; b0.dma_req = 1;
    tick();                                               // cycle 1
    chk("t4_mem_en", b0.mem_en, 1'b1);
    chk("t4_mem_we", b0.mem_we, 1'b1);
    chk("t4_mem_addr", b0.mem_addr, 32'h40);
    chk("t4_mem_wdata", b0.mem_wdata, 32'h12345678);
    chk("t4_grant", b0.grant, 2'b10);
    b0.dma_addr = 32'h99; b0.dma_wdata = 32'h0;
    tick();                                               // cycle 2
    chk("t4_c2_mem_en", b0.mem_en, 1'b0);
    chk("t4_c2_mem_addr", b0.mem_addr, 32'h40);
    tick();                                               // cycle 3
    chk("t4_c3_ack", b0.dma_ack, 1'b0);
    tick();                                               // cycle 4
    chk("t4_c4_ack", b0.dma_ack, 1'b1);
    chk("t4_cpu_rdata", b0.cpu_rdata, 32'hDEADBEEF);
    chk("t4_dma_rdata", b0.dma_rdata, 32'hA5A50020);
    b0.dma_req = 0; b0.dma_we = 0;
    tick();

    // T5: reset during WAIT, then during ISSUE, then a clean re-issue
    b0.cpu_addr = 32'h10; b0.cpu_we = 0; b0.cpu_req = 1;
    tick();                                               // ISSUE
    tick();                                               // WAIT
    reset = 1; b0.cpu_req = 0;
    #1;
    chk("t5_wait_rst_grant", b0.grant, 2'b00);
    chk("t5_wait_rst_rdata", b0.cpu_rdata, 32'h0);
    tick();
    reset = 0;
    chk("t5_rst_ack0", b0.cpu_ack, 1'b0);
    tick();
    chk("t5_rst_ack1", b0.cpu_ack, 1'b0);
    chk("t5_rst_grant1", b0.grant, 2'b00);
    tick();
    chk("t5_rst_ack2", b0.cpu_ack, 1'b0);
    b0.cpu_req = 1;
    tick();                                               // ISSUE
    chk("t5_issue_en", b0.mem_en, 1'b1);
    reset = 1; b0.cpu_req = 0;
    #1;
    chk("t5_issue_rst_en", b0.mem_en, 1'b0);
    tick();
    reset = 0;
    tick();
    b0.cpu_req = 1;                                       // cycle 0
    tick(); tick(); tick();                               // cycle 3
    chk("t5_re_c3_ack", b0.cpu_ack, 1'b0);
    tick();                                               // cycle 4
    chk("t5_re_c4_ack", b0.cpu_ack, 1'b1);
    chk("t5_re_rdata", b0.cpu_rdata, 32'hDEADBEEF);
    b0.cpu_req = 0;
    tick();

    // T6: MEM_LAT=1 instance, request dropped after grant
    b1.cpu_addr = 32'h10; b1.cpu_we = 0; b1.cpu_req = 1;  // cycle 0
    tick();                                               // cycle 1
    chk("t6_c1_mem_en", b1.mem_en, 1'b1);
    chk("t6_c1_grant", b1.grant, 2'b01);
    b1.cpu_req = 0;
    tick();                                               // cycle 2
    chk("t6_c2_ack", b1.cpu_ack, 1'b0);
    tick();                                               // cycle 3
    chk("t6_c3_ack", b1.cpu_ack, 1'b1);
    chk("t6_c3_rdata", b1.cpu_rdata, 32'hDEADBEEF);
    tick();                                               // cycle 4
    chk("t6_c4_ack", b1.cpu_ack, 1'b0);
    chk("t6_c4_grant", b1.grant, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
Sequences and shares the single memory/peripheral bus between two requesters: the multi-cycle CPU controller (port 0) and a DMA/VGA fetch engine (port 1).
- Issues one access at a time to a fixed-latency memory.
- Returns read data and a one-cycle ready/ack pulse to the winning requester.
- The CPU's MIO_ready input is driven from cpu_ack.
- Round-robin fairness by default; optional fixed CPU priority.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cpu_req  in  1  CPU access request (CPU_MIO), held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  registered CPU read data
cpu_ack  out  1  one-cycle completion pulse (to MIO_ready)
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1=write
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_rdata  out  DATA_W  registered DMA read data
dma_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory strobe, high exactly one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  valid MEM_LAT cycles after mem_en
grant  out  2  00 none, 01 CPU, 10 DMA; valid ISSUE..RESP

Behaviour:
- Reset (async): state IDLE; mem_en, mem_we, cpu_ack, dma_ack = 0; grant = 00; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; last_grant = DMA, so the CPU wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay.
  - One request: grant that requester.
  - Both requesting: grant the requester not equal to last_grant.
  - On grant: latch the winner's we/addr/wdata into mem_* registers, set grant, go to ISSUE.
- ISSUE: mem_en=1 for this cycle only; load wait counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter reaches 1 (the cycle in which mem_rdata is valid), on a read capture mem_rdata into the granted requester's rdata register.
  - Go to RESP.
- RESP:
  - Assert granted ack for exactly one cycle; update last_grant; grant returns to 00 next cycle; go to IDLE.
  - Arbitration for the next access happens in IDLE, never inside RESP.
- Latency, req seen in IDLE to ack: MEM_LAT+2 cycles (4 at default). Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Writes follow identical timing; rdata registers are unchanged by writes.
- rdata registers hold their value until that requester's next read completes.
- A requester still asserting req in the cycle after its ack is treated as a new request.
- A req dropped after grant: the access still completes and ack still pulses; the requester ignores it.
- Request inputs sampled only in IDLE; changes to addr/wdata after grant are ignored.
- Reset mid-operation: abort immediately to IDLE. No ack is produced for the aborted access; mem_en is deasserted even if in ISSUE.
- Counter width: 4 bits. MEM_LAT=1 gives one WAIT cycle.

Optional Feature:
ARB_CPU_PRIO_EN
- Defined: fixed priority; CPU always wins ties; last_grant is ignored. DMA is served only when cpu_req is low in IDLE.
- Undefined: round-robin as specified above.

Decomposition:
Shared package mio_arb_pkg:
- state enum (IDLE/ISSUE/WAIT/RESP)
- grant encodings GNT_NONE=2'b00, GNT_CPU=2'b01, GNT_DMA=2'b10
- counter width constant

Sub-module mio_rr_pick:
- Combinational 2-way pick from cpu_req, dma_req, last_grant.
- Contains the ARB_CPU_PRIO_EN switch.

Test Plan:
- CPU read only, addr 0x10, mem returns 0xDEADBEEF at MEM_LAT=2 -> mem_en high in cycle 1; cpu_ack high only in cycle 4; cpu_rdata=0xDEADBEEF; dma_ack stays 0.
- Both requests in the first cycle after reset -> CPU granted first (grant=01, ack cycle 4); DMA granted next (grant=10, ack cycle 9).
- Both held continuously for 6 accesses -> grant order CPU,DMA,CPU,DMA,CPU,DMA; with ARB_CPU_PRIO_EN defined -> all CPU, dma_ack never asserted.
- DMA write addr 0x40 data 0x12345678 -> one cycle with mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; dma_ack after MEM_LAT+2 cycles; both rdata registers unchanged.
- Reset pulsed during WAIT of a CPU read -> next cycle IDLE, grant=00, no cpu_ack; re-issued request completes normally with ack 4 cycles after the request.
- MEM_LAT=1 build, CPU read -> ack at cycle 3 with correct data.
